jtag_tap_ctrl: RTL
==================

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

Interface
REQ-001 Parameter IR_WIDTH, default 4, instruction register width in bits.
REQ-002 Parameter IDCODE_VALUE, default 32'h1000_0001, device ID returned by IDCODE; bit 0 SHALL be 1.
REQ-003 tck  input  1  test clock; sole clock of the block.
REQ-004 trst  input  1  test reset; asynchronous, active-low.
REQ-005 tms  input  1  mode select; sampled on tck rising edge.
REQ-006 tdi  input  1  serial data in; sampled on tck rising edge.
REQ-007 tdo  output  1  serial data out; changes on tck falling edge only.
REQ-008 tdo_en  output  1  high while in Shift-IR or Shift-DR; retimed on the falling edge together with tdo.
REQ-009 capture_dr, shift_dr, update_dr  output  1 each  high while the TAP is in the matching state.
REQ-010 sel_sample, sel_extest, sel_halt  output  1 each  decoded current instruction.
REQ-011 bsr_tdo  input  1  serial out of the external boundary-scan register.
REQ-012 halt_req  output  1  registered request that stops system logic.

Function
REQ-013 The TAP SHALL implement the 16 IEEE 1149.1 states with the standard TMS-driven transitions, advancing on each tck rising edge.
REQ-014 From any state, 5 consecutive rising edges with tms=1 SHALL reach Test-Logic-Reset (TLR).
REQ-015 Capture-IR SHALL load the IR shift stage with {0..0,01}, i.e. LSBs 2'b01.
REQ-016 Shift-IR SHALL shift right with tdi into the MSB; the LSB is presented to tdo.
REQ-017 Update-IR SHALL transfer the shift stage into the active IR on the rising edge leaving Update-IR.
REQ-018 In TLR the active IR SHALL be IDCODE.
REQ-019 Opcodes: EXTEST 0000, IDCODE 0001, SAMPLE_PRELOAD 0010, HALT 0110, BYPASS 1111. Every undefined opcode SHALL decode as BYPASS.
REQ-020 BYPASS and HALT SHALL select a 1-bit bypass register, which is cleared in Capture-DR.
REQ-021 IDCODE SHALL select a 32-bit register that loads IDCODE_VALUE in Capture-DR and shifts LSB-first.
REQ-022 SAMPLE_PRELOAD and EXTEST SHALL route bsr_tdo to tdo; the external register owns capture and update.
REQ-023 The tdo mux SHALL select the IR LSB in Shift-IR and the selected DR LSB in Shift-DR; in all other states tdo SHALL be 0 with tdo_en=0.
REQ-024 halt_req SHALL set on the rising edge leaving Update-IR when the new IR is HALT.
REQ-025 halt_req SHALL clear only on TLR entry or on Update-IR loading a non-HALT opcode.
REQ-026 Pause-IR and Pause-DR SHALL hold all shift contents; Exit2 back to Shift SHALL resume without loss.

Reset
REQ-027 trst low SHALL asynchronously force: state TLR, IR IDCODE, IR shift stage 0, bypass 0, halt_req 0, tdo 0, tdo_en 0.
REQ-028 trst low in mid-shift SHALL discard the partial shift; no Update SHALL occur.
REQ-029 Release of trst SHALL take effect on the next tck rising edge.

Structure
REQ-030 The package jtag_pkg SHALL hold the TAP state enum, the opcode localparams and IR_WIDTH.
REQ-031 The 16-state FSM SHALL be a sub-module jtag_tap_fsm (tck, trst, tms -> state).
REQ-032 jtag_tap_ctrl SHALL contain the IR, the DR registers, the decode logic and the negedge tdo stage.

Verification
REQ-033 Bench: from Run-Test/Idle, tms=1 for 5 edges -> state TLR, IR=0001.
REQ-034 Bench: shift IR with 0110 (tdi LSB-first 0,1,1,0) -> tdo emits 1,0,0,0; halt_req=1 after Update-IR; sel_halt=1.
REQ-035 Bench: after reset, go to Shift-DR and shift 32 bits -> tdo stream equals 32'h1000_0001, LSB-first.
REQ-036 Bench: IR=1011 (undefined); in Shift-DR apply tdi 1,0,1 -> tdo is 0,1,0 (one-cycle bypass delay).
REQ-037 Bench: trst pulsed low after 10 Shift-DR edges -> immediately TLR with tdo_en=0 and halt_req=0; no update_dr pulse.
REQ-038 Bench: IR=SAMPLE_PRELOAD; in Shift-DR bsr_tdo toggles -> tdo follows bsr_tdo, delayed to the next falling edge.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared TAP definitions: controller state encoding, default IR width and opcodes.
package jtag_pkg;

  localparam int IR_WIDTH = 4;

  typedef enum logic [3:0] {
    ST_TLR      = 4'h0,
    ST_RTI      = 4'h1,
    ST_SEL_DR   = 4'h2,
    ST_CAP_DR   = 4'h3,
    ST_SHIFT_DR = 4'h4,
    ST_EXIT1_DR = 4'h5,
    ST_PAUSE_DR = 4'h6,
    ST_EXIT2_DR = 4'h7,
    ST_UPD_DR   = 4'h8,
    ST_SEL_IR   = 4'h9,
    ST_CAP_IR   = 4'hA,
    ST_SHIFT_IR = 4'hB,
    ST_EXIT1_IR = 4'hC,
    ST_PAUSE_IR = 4'hD,
    ST_EXIT2_IR = 4'hE,
    ST_UPD_IR   = 4'hF
  } tap_state_t;

  localparam logic [IR_WIDTH-1:0] OPC_EXTEST         = 4'b0000;
  localparam logic [IR_WIDTH-1:0] OPC_IDCODE         = 4'b0001;
  localparam logic [IR_WIDTH-1:0] OPC_SAMPLE_PRELOAD = 4'b0010;
  localparam logic [IR_WIDTH-1:0] OPC_HALT           = 4'b0110;
  localparam logic [IR_WIDTH-1:0] OPC_BYPASS         = 4'b1111;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller. Next state is exported too, so the datapath can
// act on Test-Logic-Reset entry in the same edge that enters it.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t state,
  output tap_state_t next_state
);

  tap_state_t r_state;
  tap_state_t w_next;

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) r_state <= ST_TLR;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_TLR:      w_next = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      w_next = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   w_next = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   w_next = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: w_next = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: w_next = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: w_next = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: w_next = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   w_next = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   w_next = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   w_next = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: w_next = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: w_next = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: w_next = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: w_next = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   w_next = tms ? ST_SEL_DR   : ST_RTI;
      default:     w_next = ST_TLR;
    endcase
  end

  assign state      = r_state;
  assign next_state = w_next;

endmodule

// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP: instruction register, IDCODE/bypass data registers, decode and the
// falling-edge tdo stage. The boundary-scan register itself lives outside.
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH     = jtag_pkg::IR_WIDTH,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
  input  logic                 tck,
  input  logic                 trst,
  input  logic                 tms,
  input  logic                 tdi,
  output logic                 tdo,
  output logic                 tdo_en,
  output logic                 capture_dr,
  output logic                 shift_dr,
  output logic                 update_dr,
  output logic                 sel_sample,
  output logic                 sel_extest,
  output logic                 sel_halt,
  input  logic                 bsr_tdo,
  output logic                 halt_req,
  output jtag_pkg::tap_state_t o_dbg_state,
  output logic [IR_WIDTH-1:0]  o_dbg_ir
);

  jtag_pkg::tap_state_t w_state;
  jtag_pkg::tap_state_t w_next_state;

  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_shift;
  logic [31:0]         r_idcode;
  logic                r_bypass;
  logic                r_halt;
  logic                r_tdo;
  logic                r_tdo_en;

  logic w_shift_ir, w_shift_dr, w_capture_dr;
  logic w_sel_idcode, w_sel_sample, w_sel_extest, w_sel_halt, w_sel_bypass;
  logic w_tdo;

  jtag_tap_fsm u_fsm (
    .tck        (tck),
    .trst       (trst),
    .tms        (tms),
    .state      (w_state),
    .next_state (w_next_state)
  );

  assign w_shift_ir   = (w_state == jtag_pkg::ST_SHIFT_IR);
  assign w_shift_dr   = (w_state == jtag_pkg::ST_SHIFT_DR);
  assign w_capture_dr = (w_state == jtag_pkg::ST_CAP_DR);

  // Anything that is not EXTEST, IDCODE or SAMPLE_PRELOAD uses the bypass bit.
  assign w_sel_extest = (r_ir == IR_WIDTH'(jtag_pkg::OPC_EXTEST));
  assign w_sel_idcode = (r_ir == IR_WIDTH'(jtag_pkg::OPC_IDCODE));
  assign w_sel_sample = (r_ir == IR_WIDTH'(jtag_pkg::OPC_SAMPLE_PRELOAD));
  assign w_sel_halt   = (r_ir == IR_WIDTH'(jtag_pkg::OPC_HALT));
  assign w_sel_bypass = !(w_sel_extest || w_sel_idcode || w_sel_sample);

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_ir       <= IR_WIDTH'(jtag_pkg::OPC_IDCODE);
      r_ir_shift <= '0;
      r_halt     <= 1'b0;
    end else if (w_next_state == jtag_pkg::ST_TLR) begin
      r_ir   <= IR_WIDTH'(jtag_pkg::OPC_IDCODE);
      r_halt <= 1'b0;
    end else begin
      case (w_state)
        jtag_pkg::ST_CAP_IR:   r_ir_shift <= IR_WIDTH'(2'b01);
        jtag_pkg::ST_SHIFT_IR: r_ir_shift <= {tdi, r_ir_shift[IR_WIDTH-1:1]};
        jtag_pkg::ST_UPD_IR: begin
          r_ir   <= r_ir_shift;
          r_halt <= (r_ir_shift == IR_WIDTH'(jtag_pkg::OPC_HALT));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      r_idcode <= '0;
      r_bypass <= 1'b0;
    end else if (w_capture_dr) begin
      if (w_sel_idcode) r_idcode <= IDCODE_VALUE;
      if (w_sel_bypass) r_bypass <= 1'b0;
    end else if (w_shift_dr) begin
      if (w_sel_idcode) r_idcode <= {tdi, r_idcode[31:1]};
      if (w_sel_bypass) r_bypass <= tdi;
    end
  end

  always_comb begin
    w_tdo = 1'b0;
    if (w_shift_ir) begin
      w_tdo = r_ir_shift[0];
    end else if (w_shift_dr) begin
      if (w_sel_idcode)                      w_tdo = r_idcode[0];
      else if (w_sel_sample || w_sel_extest) w_tdo = bsr_tdo;
      else                                   w_tdo = r_bypass;
    end
  end

  // Falling-edge retiming gives the receiver half a cycle of setup margin.
  always_ff @(negedge tck or negedge trst) begin
    if (!trst) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo;
      r_tdo_en <= w_shift_ir || w_shift_dr;
    end
  end

  assign tdo         = r_tdo;
  assign tdo_en      = r_tdo_en;
  assign capture_dr  = w_capture_dr;
  assign shift_dr    = w_shift_dr;
  assign update_dr   = (w_state == jtag_pkg::ST_UPD_DR);
  assign sel_sample  = w_sel_sample;
  assign sel_extest  = w_sel_extest;
  assign sel_halt    = w_sel_halt;
  assign halt_req    = r_halt;
  assign o_dbg_state = w_state;
  assign o_dbg_ir    = r_ir;

endmodule
